// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared types and constants for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ADJ_THRESH = 4'd8;
    localparam bcd_digit_t ADJ_VAL    = 4'd3;
    localparam bcd_digit_t BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd2bin_seq_adj.sv
// bcd_digit_adj: reverse double-dabble correction for one BCD digit (>=8 -> -3).
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adj
);

    assign adj = (digit >= ADJ_THRESH) ? digit - ADJ_VAL : digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional input-digit validation is enabled by defining BCD2BIN_CHECK_EN.
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t                   state, state_nx;
    logic [BCD_W-1:0]         bcd_reg, bcd_nx, bcd_adj;
    logic [BIN_W-1:0]         bin_reg, bin_nx, bin_out_nx;
    logic [CNT_W-1:0]         cnt, cnt_nx;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic                     err_nx, bad, bad_reg, bad_nx;

    assign shifted = {bcd_reg, bin_reg} >> 1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (shifted[BIN_W+4*i +: 4]),
            .adj   (bcd_adj[4*i +: 4])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_in[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
`else
    assign bad = 1'b0;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // An invalid request spends one cycle in SHIFT doing nothing so done lands on edge k+1.
    always_comb begin
        state_nx   = state;
        bcd_nx     = bcd_reg;
        bin_nx     = bin_reg;
        cnt_nx     = cnt;
        bin_out_nx = bin_out;
        err_nx     = err;
        bad_nx     = bad_reg;
        case (state)
            IDLE: if (start) begin
                bcd_nx   = bcd_in;
                bin_nx   = '0;
                cnt_nx   = bad ? CNT_W'(1) : CNT_W'(BIN_W);
                bad_nx   = bad;
                state_nx = SHIFT;
            end
            SHIFT: if (bad_reg) begin
                err_nx   = 1'b1;
                state_nx = DONE;
            end else begin
                bcd_nx = bcd_adj;
                bin_nx = shifted[BIN_W-1:0];
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    bin_out_nx = shifted[BIN_W-1:0];
                    err_nx     = 1'b0;
                    state_nx   = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
            bad_reg <= 1'b0;
        end else begin
            state   <= state_nx;
            bcd_reg <= bcd_nx;
            bin_reg <= bin_nx;
            cnt     <= cnt_nx;
            bin_out <= bin_out_nx;
            err     <= err_nx;
            bad_reg <= bad_nx;
        end
    end

endmodule
